exp3_unidade_controle: RTL and testbench

//   Moore FSM that sequences the Exp3 datapath: it clears counter and register,

---
 rtl/exp3_unidade_controle_if.sv | 26 ++
 rtl/exp3_unidade_controle.sv | 135 +++++++++++++
 tb/tb_exp3_unidade_controle.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/exp3_unidade_controle_if.sv
// rtl/exp3_unidade_controle_if.sv - control/status bundle between the Exp3 controller and its datapath.
interface exp3_unidade_controle_if;
  logic       iniciar;
  logic       jogada;
  logic       chavesIgualMemoria;
  logic       fimC;
  logic       zeraC;
  logic       contaC;
  logic       zeraR;
  logic       registraR;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic       timeout;
  logic [3:0] db_estado;

  modport master (
    output iniciar, jogada, chavesIgualMemoria, fimC,
    input  zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado
  );

  modport slave (
    input  iniciar, jogada, chavesIgualMemoria, fimC,
    output zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado
  );
endinterface

// File: rtl/exp3_unidade_controle.sv
// rtl/exp3_unidade_controle.sv - Moore FSM sequencing the Exp3 play/compare datapath.
module exp3_unidade_controle #(
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       chavesIgualMemoria,
    input  logic       fimC,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL     = 4'b0000,
        PREPARACAO  = 4'b0001,
        ESPERA      = 4'b0010,
        REGISTRA    = 4'b0100,
        COMPARACAO  = 4'b0101,
        PROXIMO     = 4'b0110,
        FIM_ACERTOU = 4'b1010,
        FIM_ERROU   = 4'b1110,
        FIM_TIMEOUT = 4'b1101
    } estado_t;

    estado_t estado;
    estado_t proximo;

`ifdef TIMEOUT_EN
    localparam int            TW     = $clog2(TIMEOUT_CICLOS);
    localparam logic [TW-1:0] ULTIMO = TW'(TIMEOUT_CICLOS - 1);

    logic [TW-1:0] timer;
    logic          expirou;

    assign expirou = (timer == ULTIMO);

    always_ff @(posedge clock) begin
        if (reset) begin
            timer <= '0;
        end else if (estado == ESPERA && proximo == ESPERA) begin
            timer <= timer + TW'(1);
        end else begin
            timer <= '0;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo = INICIAL;
        case (estado)
            INICIAL:     proximo = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:  proximo = ESPERA;
            ESPERA: begin
                if (jogada) begin
                    proximo = REGISTRA;
`ifdef TIMEOUT_EN
                end else if (expirou) begin
                    proximo = FIM_TIMEOUT;
`endif
                end else begin
                    proximo = ESPERA;
                end
            end
            REGISTRA:    proximo = COMPARACAO;
            COMPARACAO: begin
                if (!chavesIgualMemoria) begin
                    proximo = FIM_ERROU;
                end else if (fimC) begin
                    proximo = FIM_ACERTOU;
                end else begin
                    proximo = PROXIMO;
                end
            end
            PROXIMO:     proximo = ESPERA;
            FIM_ACERTOU,
            FIM_ERROU,
            FIM_TIMEOUT: proximo = iniciar ? PREPARACAO : estado;
            default:     proximo = INICIAL;
        endcase
    end

    always_comb begin
        zeraC     = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        contaC    = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        case (estado)
            PREPARACAO: begin
                zeraC = 1'b1;
                zeraR = 1'b1;
            end
            REGISTRA:    registraR = 1'b1;
            PROXIMO:     contaC    = 1'b1;
            FIM_ACERTOU: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_ERROU: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto = 1'b1;
`ifdef TIMEOUT_EN
                timeout = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_exp3_unidade_controle.sv
// tb/tb_exp3_unidade_controle.sv - self-checking bench for exp3_unidade_controle with random games.
module tb_exp3_unidade_controle;
    localparam int TC = 10;

    localparam logic [7:0] O_NONE  = 8'b0000_0000;
    localparam logic [7:0] O_PREP  = 8'b1010_0000;
    localparam logic [7:0] O_REG   = 8'b0001_0000;
    localparam logic [7:0] O_CONTA = 8'b0100_0000;
    localparam logic [7:0] O_ACERT = 8'b0000_1100;
    localparam logic [7:0] O_ERR   = 8'b0000_1010;
    localparam logic [7:0] O_TMO   = 8'b0000_1001;

    logic clock = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cnt_reg = 0;
    int   cnt_conta = 0;

    logic       iniciar;
    logic       jogada;
    logic       chavesIgualMemoria;
    logic       fimC;
    logic       zeraC;
    logic       contaC;
    logic       zeraR;
    logic       registraR;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic [3:0] db_estado;

    exp3_unidade_controle #(.TIMEOUT_CICLOS(TC)) dut (
        .clock              (clock),
        .reset              (reset),
        .iniciar            (iniciar),
        .jogada             (jogada),
        .chavesIgualMemoria (chavesIgualMemoria),
        .fimC               (fimC),
        .zeraC              (zeraC),
        .contaC             (contaC),
        .zeraR              (zeraR),
        .registraR          (registraR),
        .pronto             (pronto),
        .acertou            (acertou),
        .errou              (errou),
        .timeout            (timeout),
        .db_estado          (db_estado)
    );

    always #5 clock = ~clock;

    function automatic logic [11:0] snap();
        return {db_estado, zeraC, contaC, zeraR, registraR,
                pronto, acertou, errou, timeout};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (registraR === 1'b1) cnt_reg++;
        if (contaC === 1'b1) cnt_conta++;
    endtask

    task automatic play(input logic eq, input logic fim, output logic done);
        int gap;
        gap = $urandom_range(0, 4);
        for (int g = 0; g < gap; g++) begin
            iniciar = 1'($urandom_range(0, 1));
            step();
            chk("espera_hold", 32'(snap()), {20'h0, 4'h2, O_NONE});
        end
        iniciar            = 1'b0;
        jogada             = 1'b1;
        chavesIgualMemoria = eq;
        fimC               = fim;
        step();
        jogada = 1'($urandom_range(0, 1));
        chk("registra", 32'(snap()), {20'h0, 4'h4, O_REG});
        step();
        jogada = 1'($urandom_range(0, 1));
        chk("comparacao", 32'(snap()), {20'h0, 4'h5, O_NONE});
        step();
        jogada = 1'b0;
        done = 1'b1;
        if (!eq) begin
            chk("fim_errou", 32'(snap()), {20'h0, 4'hE, O_ERR});
        end else if (fim) begin
            chk("fim_acertou", 32'(snap()), {20'h0, 4'hA, O_ACERT});
        end else begin
            chk("proximo", 32'(snap()), {20'h0, 4'h6, O_CONTA});
            step();
            chk("volta_espera", 32'(snap()), {20'h0, 4'h2, O_NONE});
            done = 1'b0;
        end
    endtask

    task automatic run_game(input int bad);
        logic done;
        int   n_plays;
        int   hold;
        logic [11:0] fim_snap;
        cnt_reg   = 0;
        cnt_conta = 0;
        done      = 1'b0;
        n_plays   = 0;
        for (int p = 1; p <= 16 && !done; p++) begin
            play(p != bad, p == 16, done);
            n_plays++;
        end
        chk("n_jogadas", 32'(n_plays), 32'((bad == 0) ? 16 : bad));
        chk("n_registraR", 32'(cnt_reg), 32'(n_plays));
        chk("n_contaC", 32'(cnt_conta), 32'(n_plays - 1));
        fim_snap = (bad == 0) ? {4'hA, O_ACERT} : {4'hE, O_ERR};
        hold = $urandom_range(1, 3);
        for (int h = 0; h < hold; h++) begin
            jogada = 1'($urandom_range(0, 1));
            step();
            chk("fim_hold", 32'(snap()), 32'(fim_snap));
        end
        jogada  = 1'b0;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        chk("reinicio_prep", 32'(snap()), {20'h0, 4'h1, O_PREP});
        step();
        chk("reinicio_espera", 32'(snap()), {20'h0, 4'h2, O_NONE});
    endtask

    initial begin
        iniciar            = 1'b0;
        jogada             = 1'b0;
        chavesIgualMemoria = 1'b0;
        fimC               = 1'b0;
        reset              = 1'b1;
        step();
        step();
        chk("reset_estado", 32'(snap()), {20'h0, 4'h0, O_NONE});
        reset = 1'b0;
        step();
        chk("inicial_hold", 32'(snap()), {20'h0, 4'h0, O_NONE});
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        chk("preparacao", 32'(snap()), {20'h0, 4'h1, O_PREP});
        step();
        chk("espera", 32'(snap()), {20'h0, 4'h2, O_NONE});

        run_game(0);
        run_game(3);
        run_game(16);
        for (int r = 0; r < 5; r++) begin
            run_game($urandom_range(0, 16));
        end

        jogada             = 1'b1;
        chavesIgualMemoria = 1'b1;
        fimC               = 1'b0;
        step();
        jogada = 1'b0;
        step();
        chk("antes_reset", 32'(snap()), {20'h0, 4'h5, O_NONE});
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("reset_em_comparacao", 32'(snap()), {20'h0, 4'h0, O_NONE});
        jogada = 1'b1;
        step();
        jogada = 1'b0;
        chk("jogada_em_inicial", 32'(snap()), {20'h0, 4'h0, O_NONE});
        step();
        chk("inicial_estavel", 32'(snap()), {20'h0, 4'h0, O_NONE});

        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        step();
        chk("espera_timer", 32'(snap()), {20'h0, 4'h2, O_NONE});
`ifdef TIMEOUT_EN
        for (int k = 2; k <= TC; k++) begin
            step();
            chk("espera_antes_timeout", 32'(snap()), {20'h0, 4'h2, O_NONE});
        end
        step();
        chk("fim_timeout", 32'(snap()), {20'h0, 4'hD, O_TMO});
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        step();
        for (int k = 2; k <= TC; k++) begin
            step();
        end
        chk("espera_ultimo_ciclo", 32'(snap()), {20'h0, 4'h2, O_NONE});
        jogada = 1'b1;
        step();
        jogada = 1'b0;
        chk("jogada_vence_timeout", 32'(snap()), {20'h0, 4'h4, O_REG});
`else
        for (int k = 0; k < 200; k++) begin
            step();
        end
        chk("espera_sem_timeout", 32'(snap()), {20'h0, 4'h2, O_NONE});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
